// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the SRAM sequencer/arbiter: FSM encodings,
// requester port indices and wait-counter width.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Holds WAIT_CYCLES-1 for the legal range 1..15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins,
// a tie goes to the port that was not served last.
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant_valid,
  output logic grant_port
);

  always_comb begin
    grant_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      grant_port = ~last;
    end else if (valid1) begin
      grant_port = PORT_DMA;
    end else begin
      grant_port = PORT_CPU;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for an asynchronous SRAM.
// Strobes, done pulses, busy and read data all come straight from flops.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AddressSize = 16,
  parameter int unsigned WordSize    = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic                   req0_we,
  input  logic [AddressSize-1:0] req0_addr,
  input  logic [WordSize-1:0]    req0_wdata,
  input  logic                   req1_valid,
  input  logic                   req1_we,
  input  logic [AddressSize-1:0] req1_addr,
  input  logic [WordSize-1:0]    req1_wdata,
  output logic                   done0,
  output logic                   done1,
  output logic [WordSize-1:0]    rdata,
  output logic                   busy,
  output logic [AddressSize-1:0] ram_addr,
  output logic [WordSize-1:0]    ram_wdata,
  input  logic [WordSize-1:0]    ram_rdata,
  output logic                   ram_cs_bar,
  output logic                   ram_we_bar,
  output logic                   ram_oe_bar
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic                   port_q, port_d;
  logic                   we_q, we_d;
  logic [AddressSize-1:0] addr_q, addr_d;
  logic [WordSize-1:0]    wdata_q, wdata_d;
  logic [WordSize-1:0]    rdata_q, rdata_d;
  logic                   cs_bar_q, cs_bar_d;
  logic                   we_bar_q, we_bar_d;
  logic                   oe_bar_q, oe_bar_d;
  logic                   done0_q, done0_d;
  logic                   done1_q, done1_d;
  logic                   busy_q, busy_d;
  logic                   pick_valid;
  logic                   pick_port;

  rr_pick2 u_pick (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last        (last_q),
    .grant_valid (pick_valid),
    .grant_port  (pick_port)
  );

  // Next state, latched request and read capture; strobes follow the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          port_d  = pick_port;
          last_d  = pick_port;
          we_d    = (pick_port == PORT_DMA) ? req1_we    : req0_we;
          addr_d  = (pick_port == PORT_DMA) ? req1_addr  : req0_addr;
          wdata_d = (pick_port == PORT_DMA) ? req1_wdata : req0_wdata;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_RELEASE;
          if (!we_q) begin
            rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // WE only ever falls in STROBE on a write, OE only on a read, so they never overlap.
    cs_bar_d = (state_d == ST_IDLE);
    we_bar_d = !((state_d == ST_STROBE) && we_d);
    oe_bar_d = !(((state_d == ST_SETUP) || (state_d == ST_STROBE)) && !we_d);
    done0_d  = (state_d == ST_RELEASE) && (port_d == PORT_CPU);
    done1_d  = (state_d == ST_RELEASE) && (port_d == PORT_DMA);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= PORT_DMA;
      port_q   <= PORT_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cs_bar_q <= 1'b1;
      we_bar_q <= 1'b1;
      oe_bar_q <= 1'b1;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cs_bar_q <= cs_bar_d;
      we_bar_q <= we_bar_d;
      oe_bar_q <= oe_bar_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
    end
  end

  assign done0      = done0_q;
  assign done1      = done1_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign ram_cs_bar = cs_bar_q;
  assign ram_we_bar = we_bar_q;
  assign ram_oe_bar = oe_bar_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: SRAM model, scoreboard of completions, strobe-order
// monitor, table-driven accesses and hand-written multi-cycle sequences.
module tb_ram_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int W = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance (WAIT_CYCLES=2)
  logic          r_valid [2];
  logic          r_we    [2];
  logic [AW-1:0] r_addr  [2];
  logic [DW-1:0] r_wdata [2];
  logic          done0, done1, busy;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_cs_bar, ram_we_bar, ram_oe_bar;

  ram_arbiter #(.AddressSize(AW), .WordSize(DW), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(r_valid[0]), .req0_we(r_we[0]), .req0_addr(r_addr[0]), .req0_wdata(r_wdata[0]),
    .req1_valid(r_valid[1]), .req1_we(r_we[1]), .req1_addr(r_addr[1]), .req1_wdata(r_wdata[1]),
    .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_cs_bar(ram_cs_bar), .ram_we_bar(ram_we_bar), .ram_oe_bar(ram_oe_bar)
  );

  // Second instance built with WAIT_CYCLES=1, port 1 idle
  logic          b_valid, b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_idle_valid = 1'b0;
  logic          b_idle_we = 1'b0;
  logic [AW-1:0] b_idle_addr = '0;
  logic [DW-1:0] b_idle_wdata = '0;
  logic          done0_b, done1_b, busy_b;
  logic [DW-1:0] rdata_b, ram_wdata_b, ram_rdata_b;
  logic [AW-1:0] ram_addr_b;
  logic          ram_cs_bar_b, ram_we_bar_b, ram_oe_bar_b;

  ram_arbiter #(.AddressSize(AW), .WordSize(DW), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .reset(reset),
    .req0_valid(b_valid), .req0_we(b_we), .req0_addr(b_addr), .req0_wdata(b_wdata),
    .req1_valid(b_idle_valid), .req1_we(b_idle_we), .req1_addr(b_idle_addr), .req1_wdata(b_idle_wdata),
    .done0(done0_b), .done1(done1_b), .rdata(rdata_b), .busy(busy_b),
    .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b),
    .ram_cs_bar(ram_cs_bar_b), .ram_we_bar(ram_we_bar_b), .ram_oe_bar(ram_oe_bar_b)
  );

  // Untimed SRAM models: write on the WE rising edge, read while CS and OE are low
  logic [DW-1:0] mem  [0:65535];
  logic [DW-1:0] mem1 [0:65535];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]  = init_val(16'(i));
      mem1[i] = init_val(16'(i));
    end
  end

  always @(posedge ram_we_bar)   if (!reset && !ram_cs_bar)   mem[ram_addr]    = ram_wdata;
  always @(posedge ram_we_bar_b) if (!reset && !ram_cs_bar_b) mem1[ram_addr_b] = ram_wdata_b;
  assign ram_rdata   = (!ram_cs_bar && !ram_oe_bar)     ? mem[ram_addr]    : 8'hEE;
  assign ram_rdata_b = (!ram_cs_bar_b && !ram_oe_bar_b) ? mem1[ram_addr_b] : 8'hEE;

  // Independent record of what the bench has written
  logic [DW-1:0] shadow [logic [AW-1:0]];
  function automatic logic [DW-1:0] exp_mem(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic          port;
    logic          we;
    logic [DW-1:0] rdata;
  } sb_t;
  sb_t sbq[$];
  sb_t sb_e;

  logic          prev_we = 1'b1;
  logic          prev_cs = 1'b1;
  logic [AW-1:0] prev_addr = '0;

  // Completion scoreboard and strobe-ordering monitor
  always @(negedge clk) begin
    check("we_oe_overlap", 32'(ram_we_bar | ram_oe_bar), 32'd1);
    check("we_oe_overlap_w1", 32'(ram_we_bar_b | ram_oe_bar_b), 32'd1);
    if (!reset) begin
      if (done0 || done1) begin
        if (sbq.size() == 0) begin
          check("done_unexpected", 32'({done1, done0}), 32'd0);
        end else begin
          sb_e = sbq.pop_front();
          check("done_port", 32'({done1, done0}), sb_e.port ? 32'd2 : 32'd1);
          if (!sb_e.we) check("rdata", 32'(rdata), 32'(sb_e.rdata));
        end
      end
      if (prev_we && !ram_we_bar) begin
        check("addr_stable_before_we", 32'(ram_addr), 32'(prev_addr));
        check("cs_low_before_we", 32'(prev_cs), 32'd0);
      end
      if (!prev_we && ram_we_bar) check("cs_low_at_we_rise", 32'(ram_cs_bar), 32'd0);
    end
    prev_we   <= ram_we_bar;
    prev_cs   <= ram_cs_bar;
    prev_addr <= ram_addr;
  end

  task automatic wait_done(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((p == 0 && done0) || (p == 1 && done1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // n back-to-back accesses from one port, valid held across done
  task automatic run_port(input int p, input int n, input logic we, input logic [AW-1:0] base,
                          input logic [DW-1:0] dbase, input bit push, input int spacing,
                          input int first_lat);
    int start, t, last_t;
    bit ok;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    last_t = 0;
    for (int k = 0; k < n; k++) begin
      a = base + AW'(k);
      d = dbase + DW'(k);
      r_we[p] = we; r_addr[p] = a; r_wdata[p] = d; r_valid[p] = 1'b1;
      start = cyc;
      if (push) sbq.push_back('{port: 1'(p), we: we, rdata: exp_mem(a)});
      if (we) shadow[a] = d;
      wait_done(p, ok);
      if (!ok) begin
        check("done_timeout", 32'd0, 32'd1);
        r_valid[p] = 1'b0;
        return;
      end
      t = cyc;
      if (k == 0 && first_lat >= 0) check("first_latency", 32'(t - start), 32'(first_lat));
      if (k > 0 && spacing > 0) check("done_spacing", 32'(t - last_t), 32'(spacing));
      last_t = t;
      @(posedge clk); #1;
    end
    r_valid[p] = 1'b0;
  endtask

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int start;
    bit ok;

    vecs[0] = '{0, 1'b1, 16'h1234, 8'hA5, 8'h00};
    vecs[1] = '{0, 1'b0, 16'h1234, 8'h00, 8'hA5};
    vecs[2] = '{1, 1'b1, 16'hFFFF, 8'hC3, 8'h00};
    vecs[3] = '{1, 1'b0, 16'hFFFF, 8'h00, 8'hC3};
    vecs[4] = '{0, 1'b0, 16'h0000, 8'h00, 8'h5A};
    vecs[5] = '{1, 1'b1, 16'h0000, 8'h00, 8'h00};
    vecs[6] = '{0, 1'b0, 16'h0000, 8'h00, 8'h00};
    vecs[7] = '{1, 1'b0, 16'h0020, 8'h00, 8'h3C};

    for (int p = 0; p < 2; p++) begin
      r_valid[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_wdata[p] = '0;
    end
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_cs_bar", 32'(ram_cs_bar), 32'd1);
    check("rst_we_bar", 32'(ram_we_bar), 32'd1);
    check("rst_oe_bar", 32'(ram_oe_bar), 32'd1);
    check("rst_done", 32'({done1, done0}), 32'd0);
    check("rst_busy", 32'({busy_b, busy}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    @(posedge clk); #5 reset = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests: port 0 reads, port 1 writes, grants alternate 0,1,0,1
    for (int k = 0; k < 3; k++) begin
      sbq.push_back('{port: 1'b0, we: 1'b0, rdata: exp_mem(16'h0010 + AW'(k))});
      sbq.push_back('{port: 1'b1, we: 1'b1, rdata: 8'h00});
    end
    fork
      run_port(0, 3, 1'b0, 16'h0010, 8'h00, 1'b0, 10, W + 2);
      run_port(1, 3, 1'b1, 16'h0020, 8'h3C, 1'b0, 10, -1);
    join
    check("idle_busy", 32'(busy), 32'd0);

    // Table-driven single accesses
    foreach (vecs[i]) begin
      sbq.push_back('{port: 1'(vecs[i].port), we: vecs[i].we, rdata: vecs[i].exp_rdata});
      run_port(vecs[i].port, 1, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, 0, W + 2);
    end

    // Back-to-back writes from port 1, then back-to-back readback from port 0
    run_port(1, 16, 1'b1, 16'h0100, 8'h00, 1'b1, W + 3, W + 2);
    run_port(0, 16, 1'b0, 16'h0100, 8'h00, 1'b1, W + 3, W + 2);

    // Reset in the middle of a write's STROBE phase
    r_we[0] = 1'b1; r_addr[0] = 16'h4000; r_wdata[0] = 8'h77; r_valid[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ram_we_bar) begin ok = 1'b1; break; end
    end
    check("mid_write_reached", 32'(ok), 32'd1);
    @(posedge clk); #5 reset = 1'b1;
    #1;
    check("rst_mid_cs_bar", 32'(ram_cs_bar), 32'd1);
    check("rst_mid_we_bar", 32'(ram_we_bar), 32'd1);
    check("rst_mid_oe_bar", 32'(ram_oe_bar), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'({done1, done0}), 32'd0);
    check("rst_mid_rdata", 32'(rdata), 32'd0);
    check("rst_mid_ram_addr", 32'(ram_addr), 32'd0);
    r_valid[0] = 1'b0;
    @(posedge clk); @(posedge clk); #5 reset = 1'b0;
    @(posedge clk); #1;

    // Tie after reset goes to port 0 even though port 0 was granted last before reset
    sbq.push_back('{port: 1'b0, we: 1'b0, rdata: exp_mem(16'h1234)});
    sbq.push_back('{port: 1'b1, we: 1'b0, rdata: exp_mem(16'h0020)});
    fork
      run_port(0, 1, 1'b0, 16'h1234, 8'h00, 1'b0, 0, W + 2);
      run_port(1, 1, 1'b0, 16'h0020, 8'h00, 1'b0, 0, 2 * W + 5);
    join
    check("sb_drained", 32'(sbq.size()), 32'd0);

    // WAIT_CYCLES=1 instance: write then read 0xFF at the top address
    for (int k = 0; k < 2; k++) begin
      b_we = (k == 0); b_addr = 16'hFFFF; b_wdata = 8'hFF; b_valid = 1'b1;
      start = cyc;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        check("w1_no_done1", 32'(done1_b), 32'd0);
        if (done0_b) begin ok = 1'b1; break; end
      end
      check("w1_done_seen", 32'(ok), 32'd1);
      check("w1_latency", 32'(cyc - start), 32'd3);
      if (k == 1) check("w1_rdata", 32'(rdata_b), 32'hFF);
      @(posedge clk); #1;
      b_valid = 1'b0;
    end
    @(negedge clk);
    check("w1_idle_busy", 32'(busy_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule
